// File: rtl/riscv_pkg.sv
// Shared types for the RV32 hazard controller:
// forwarding selects, FSM states, shadow stage record.
package riscv_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       regwrite;
    logic       load;
  } shadow_t;

  localparam shadow_t BUBBLE = '{
    rd:       5'd0,
    rs1:      5'd0,
    rs2:      5'd0,
    regwrite: 1'b0,
    load:     1'b0
  };

  // M stage wins over W; x0 is never forwarded
  function automatic logic [1:0] fwd_sel(
    input logic       m_we,
    input logic [4:0] m_rd,
    input logic       w_we,
    input logic [4:0] w_rd,
    input logic [4:0] rs
  );
    logic [1:0] sel;
    sel = FWD_REG;
    if (m_we && m_rd != 5'd0 && m_rd == rs)
      sel = FWD_MEM;
    else if (w_we && w_rd != 5'd0 && w_rd == rs)
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_shadow_stage.sv
// One shadow pipeline register tracking rd/rs/regwrite/load
// of the instruction in a stage; flush inserts a bubble.
module hazard_shadow_stage
  import riscv_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    i_flush,
  input  shadow_t i_d,
  output shadow_t o_q
);

  shadow_t r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_q <= BUBBLE;
    else if (i_flush)
      r_q <= BUBBLE;
    else
      r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: forwarding, load-use stall,
// branch flush and saturating stall/flush perf counters.
module hazard_control_unit
  import riscv_pkg::*;
#(
  parameter int LOAD_USE_CYCLES = 1,
  parameter int CNT_W           = 16
)(
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             RegWriteD,
  input  logic             ResultSrcD,
  input  logic             PCSrcE,
  input  logic             cnt_clr,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] LUC_M1 = 2'(LOAD_USE_CYCLES - 1);

  shadow_t          w_d;
  shadow_t          w_e;
  shadow_t          w_m;
  shadow_t          w_w;
  logic             w_hzd;
  logic             w_stall;
  logic             w_unused;
  hz_state_e        r_state;
  logic [1:0]       r_ctr;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_d = '{
    rd:       RdD,
    rs1:      Rs1D,
    rs2:      Rs2D,
    regwrite: RegWriteD,
    load:     ResultSrcD
  };

  hazard_shadow_stage u_e (
    .clk     (clk),
    .reset   (reset),
    .i_flush (FlushE),
    .i_d     (w_d),
    .o_q     (w_e)
  );

  hazard_shadow_stage u_m (
    .clk     (clk),
    .reset   (reset),
    .i_flush (1'b0),
    .i_d     (w_e),
    .o_q     (w_m)
  );

  hazard_shadow_stage u_w (
    .clk     (clk),
    .reset   (reset),
    .i_flush (1'b0),
    .i_d     (w_m),
    .o_q     (w_w)
  );

  assign w_unused = ^{w_m.rs1, w_m.rs2, w_m.load,
                      w_w.rs1, w_w.rs2, w_w.load};

  assign ForwardAE = fwd_sel(w_m.regwrite, w_m.rd,
                             w_w.regwrite, w_w.rd, w_e.rs1);
  assign ForwardBE = fwd_sel(w_m.regwrite, w_m.rd,
                             w_w.regwrite, w_w.rd, w_e.rs2);

  assign w_hzd = w_e.load && (w_e.rd != 5'd0) &&
                 ((w_e.rd == Rs1D) || (w_e.rd == Rs2D));

  // a taken branch squashes D, so any stall is dropped
  assign w_stall = !PCSrcE &&
                   ((r_state == ST_STALL) || w_hzd);

  assign StallF = w_stall;
  assign StallD = w_stall;
  assign FlushD = PCSrcE;
  assign FlushE = PCSrcE || w_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_ctr   <= 2'd0;
    end else if (PCSrcE) begin
      r_state <= ST_RUN;
      r_ctr   <= 2'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_hzd) begin
            r_ctr <= LUC_M1;
            if (LUC_M1 != 2'd0)
              r_state <= ST_STALL;
          end
        end
        ST_STALL: begin
          r_ctr <= r_ctr - 2'd1;
          if (r_ctr <= 2'd1)
            r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (PCSrcE && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed table, scripted
// corner sequences and randomized reference-model checks.
module tb_hazard_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1d, rs2d, rdd;
  logic        wed, ldd, pc, clr;

  logic [1:0]  fa1, fb1, fa2, fb2;
  logic        sf1, sd1, fd1, fe1;
  logic        sf2, sd2, fd2, fe2;
  logic [15:0] sc1, fc1;
  logic [3:0]  sc2, fc2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_control_unit u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .Rs1D       (rs1d),
    .Rs2D       (rs2d),
    .RdD        (rdd),
    .RegWriteD  (wed),
    .ResultSrcD (ldd),
    .PCSrcE     (pc),
    .cnt_clr    (clr),
    .ForwardAE  (fa1),
    .ForwardBE  (fb1),
    .StallF     (sf1),
    .StallD     (sd1),
    .FlushD     (fd1),
    .FlushE     (fe1),
    .stall_cnt  (sc1),
    .flush_cnt  (fc1)
  );

  hazard_control_unit #(
    .LOAD_USE_CYCLES (2),
    .CNT_W           (4)
  ) u_dut2 (
    .clk        (clk),
    .reset      (reset),
    .Rs1D       (rs1d),
    .Rs2D       (rs2d),
    .RdD        (rdd),
    .RegWriteD  (wed),
    .ResultSrcD (ldd),
    .PCSrcE     (pc),
    .cnt_clr    (clr),
    .ForwardAE  (fa2),
    .ForwardBE  (fb2),
    .StallF     (sf2),
    .StallD     (sd2),
    .FlushD     (fd2),
    .FlushE     (fe2),
    .stall_cnt  (sc2),
    .flush_cnt  (fc2)
  );

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       we, ld, pc;
    logic [1:0] fa, fb;
    logic       st, fd, fe;
  } vec_t;

  typedef struct packed {
    logic [4:0] rd, rs1, rs2;
    logic       we, ld;
  } rec_t;

  vec_t tv[19];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d",
               nm, act, exp);
    end
  endtask

  task automatic drv(input logic [4:0] a, b, d,
                     input logic we, ld, p);
    rs1d = a; rs2d = b; rdd = d;
    wed = we; ldd = ld; pc = p;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clr = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  function automatic vec_t mk(int a, int b, int d,
                              int we, int ld, int p,
                              int fa, int fb, int st,
                              int fd, int fe);
    vec_t v;
    v.rs1 = 5'(a); v.rs2 = 5'(b); v.rd = 5'(d);
    v.we = 1'(we); v.ld = 1'(ld); v.pc = 1'(p);
    v.fa = 2'(fa); v.fb = 2'(fb);
    v.st = 1'(st); v.fd = 1'(fd); v.fe = 1'(fe);
    return v;
  endfunction

  function automatic logic [1:0] fsel(rec_t m, rec_t w,
                                      logic [4:0] rs);
    if (m.we && m.rd != 0 && m.rd == rs) return 2'd2;
    if (w.we && w.rd != 0 && w.rd == rs) return 2'd1;
    return 2'd0;
  endfunction

  // reference model state: [k] = dut index, pipe 0=E 1=M 2=W
  rec_t mp[2][3];
  int   extra[2];
  int   mscnt[2];
  int   mfcnt[2];

  initial begin
    int luc[2];
    int cmax[2];
    luc[0] = 1;     luc[1] = 2;
    cmax[0] = 65535; cmax[1] = 15;

    tv[0]  = mk(1, 2, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    tv[1]  = mk(5, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0);
    tv[2]  = mk(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    tv[3]  = mk(1, 5, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    tv[4]  = mk(2, 3, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    tv[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[6]  = mk(1, 5, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    tv[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tv[8]  = mk(1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0);
    tv[9]  = mk(5, 5, 6, 1, 0, 0, 0, 0, 1, 0, 1);
    tv[10] = mk(5, 5, 6, 1, 0, 0, 0, 0, 0, 0, 0);
    tv[11] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    tv[12] = mk(1, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0);
    tv[13] = mk(8, 0, 9, 1, 0, 1, 0, 0, 0, 1, 1);
    tv[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[15] = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tv[16] = mk(0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0);
    tv[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset state, with a load-like D to tempt the detector
    reset = 1'b0;
    clr = 1'b0;
    drv(5, 5, 5, 1, 1, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst.fa1", fa1, 0);
    chk("rst.fb1", fb1, 0);
    chk("rst.st1", {sf1, sd1, fd1, fe1}, 0);
    chk("rst.cnt1", {sc1, fc1}, 0);
    chk("rst.st2", {sf2, sd2, fd2, fe2}, 0);
    chk("rst.cnt2", {sc2, fc2}, 0);
    drv(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();

    // directed table on the LOAD_USE_CYCLES=1 instance
    for (int i = 0; i < 19; i++) begin
      drv(tv[i].rs1, tv[i].rs2, tv[i].rd,
          tv[i].we, tv[i].ld, tv[i].pc);
      @(negedge clk);
      chk($sformatf("v%0d.fa", i), fa1, tv[i].fa);
      chk($sformatf("v%0d.fb", i), fb1, tv[i].fb);
      chk($sformatf("v%0d.sf", i), sf1, tv[i].st);
      chk($sformatf("v%0d.sd", i), sd1, tv[i].st);
      chk($sformatf("v%0d.fd", i), fd1, tv[i].fd);
      chk($sformatf("v%0d.fe", i), fe1, tv[i].fe);
      if (i == 10) chk("v10.scnt", sc1, 1);
      tick();
    end
    chk("tbl.scnt", sc1, 1);
    chk("tbl.fcnt", fc1, 1);

    // load-use with two stall cycles
    do_reset();
    drv(1, 0, 5, 1, 1, 0);
    @(negedge clk);
    chk("l2.c0.sd", sd2, 0);
    tick();
    drv(5, 5, 6, 1, 0, 0);
    @(negedge clk);
    chk("l2.c1.sd", {sf2, sd2, fd2, fe2}, 4'b1101);
    tick();
    @(negedge clk);
    chk("l2.c2.sd", {sf2, sd2, fd2, fe2}, 4'b1101);
    tick();
    @(negedge clk);
    chk("l2.c3.sd", {sf2, sd2, fd2, fe2}, 4'b0000);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("l2.scnt", sc2, 2);
    tick();

    // reset asserted while the FSM sits in STALL
    drv(1, 0, 5, 1, 1, 0);
    tick();
    drv(5, 5, 6, 1, 0, 0);
    tick();
    @(negedge clk);
    chk("mid.pre.sd", sd2, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid.out2", {fa2, fb2, sf2, sd2, fd2, fe2}, 0);
    chk("mid.cnt2", {sc2, fc2}, 0);
    chk("mid.out1", {fa1, fb1, sf1, sd1, fd1, fe1}, 0);
    @(negedge clk);
    chk("mid.hold2", {sf2, sd2, fe2}, 0);
    drv(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();

    // saturation and clear priority
    drv(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 18; i++) tick();
    chk("sat.fc2", fc2, 15);
    chk("sat.fc1", fc1, 18);
    chk("sat.sc2", sc2, 0);
    tick();
    chk("sat.hold2", fc2, 15);
    clr = 1'b1;
    tick();
    chk("clr.fc2", fc2, 0);
    chk("clr.fc1", fc1, 0);
    clr = 1'b0;
    tick();
    chk("post.fc2", fc2, 1);
    drv(0, 0, 0, 0, 0, 0);

    // randomized run against the reference model
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 3; s++) mp[k][s] = '0;
      extra[k] = 0;
      mscnt[k] = 0;
      mfcnt[k] = 0;
    end
    for (int i = 0; i < 600; i++) begin
      rec_t d;
      logic p, c;
      d.rs1 = 5'($urandom_range(0, 3));
      d.rs2 = 5'($urandom_range(0, 3));
      d.rd  = 5'($urandom_range(0, 3));
      d.we  = 1'($urandom_range(0, 1));
      d.ld  = ($urandom_range(0, 2) == 0);
      p = ($urandom_range(0, 7) == 0);
      c = ($urandom_range(0, 40) == 0);
      drv(d.rs1, d.rs2, d.rd, d.we, d.ld, p);
      clr = c;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        rec_t e, m, w;
        logic hz, st, fd, fe;
        logic [1:0] ea, eb;
        logic [1:0] aa, ab;
        logic [3:0] actl;
        int asc, afc;
        e = mp[k][0]; m = mp[k][1]; w = mp[k][2];
        ea = fsel(m, w, e.rs1);
        eb = fsel(m, w, e.rs2);
        hz = e.ld && e.rd != 0 &&
             (e.rd == d.rs1 || e.rd == d.rs2);
        st = !p && (extra[k] > 0 || hz);
        fd = p;
        fe = p || st;
        if (k == 0) begin
          aa = fa1; ab = fb1;
          actl = {sf1, sd1, fd1, fe1};
          asc = int'(sc1); afc = int'(fc1);
        end else begin
          aa = fa2; ab = fb2;
          actl = {sf2, sd2, fd2, fe2};
          asc = int'(sc2); afc = int'(fc2);
        end
        chk($sformatf("r%0d.%0d.fa", i, k), aa, ea);
        chk($sformatf("r%0d.%0d.fb", i, k), ab, eb);
        chk($sformatf("r%0d.%0d.ctl", i, k), actl,
            {st, st, fd, fe});
        chk($sformatf("r%0d.%0d.sc", i, k), asc, mscnt[k]);
        chk($sformatf("r%0d.%0d.fc", i, k), afc, mfcnt[k]);
        if (p) extra[k] = 0;
        else if (extra[k] > 0) extra[k]--;
        else if (hz) extra[k] = luc[k] - 1;
        if (c) begin
          mscnt[k] = 0;
          mfcnt[k] = 0;
        end else begin
          if (st && mscnt[k] < cmax[k]) mscnt[k]++;
          if (p && mfcnt[k] < cmax[k]) mfcnt[k]++;
        end
        mp[k][2] = m;
        mp[k][1] = e;
        mp[k][0] = fe ? rec_t'('0) : d;
      end
      tick();
    end
    clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
